// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
// ----------------
// Shares one downstream sram-like memory port between the instruction-fetch
// port (inst_sram_*) and the load/store port (data_sram_*).
//
// Ports
//   clk, rstn            : clock, asynchronous active-low reset
//   inst_sram_*          : fetch request in (req/wr/size/wstrb/addr/wdata),
//                          addr_ok/data_ok/rdata back to fetch
//   data_sram_*          : load/store request in, same field meaning
//   mem_*                : downstream request out, mem_addr_ok/mem_data_ok/
//                          mem_rdata back from the memory side
//   dbg_state            : current arbiter state (0=IDLE, 1=LOCK_I, 2=LOCK_D)
//   dbg_count            : number of accepted-but-not-returned transactions
//
// Handshake: an address phase completes in the cycle where req and addr_ok
// are both high; responses come back strictly in address-accept order, one
// per mem_data_ok pulse. The grant is round-robin on ties and is held
// (LOCK_I/LOCK_D) until the downstream accepts the address. An in-order FIFO
// of 1-bit requester IDs (0=inst, 1=data) routes each response back.
module sram_bus_arbiter #(
  parameter int MAX_OUT = 4
) (
  input  logic                       clk,
  input  logic                       rstn,

  input  logic                       inst_sram_req,
  input  logic                       inst_sram_wr,
  input  logic [1:0]                 inst_sram_size,
  input  logic [3:0]                 inst_sram_wstrb,
  input  logic [31:0]                inst_sram_addr,
  input  logic [31:0]                inst_sram_wdata,
  output logic                       inst_sram_addr_ok,
  output logic                       inst_sram_data_ok,
  output logic [31:0]                inst_sram_rdata,

  input  logic                       data_sram_req,
  input  logic                       data_sram_wr,
  input  logic [1:0]                 data_sram_size,
  input  logic [3:0]                 data_sram_wstrb,
  input  logic [31:0]                data_sram_addr,
  input  logic [31:0]                data_sram_wdata,
  output logic                       data_sram_addr_ok,
  output logic                       data_sram_data_ok,
  output logic [31:0]                data_sram_rdata,

  output logic                       mem_req,
  output logic                       mem_wr,
  output logic [1:0]                 mem_size,
  output logic [3:0]                 mem_wstrb,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_addr_ok,
  input  logic                       mem_data_ok,
  input  logic [31:0]                mem_rdata,

  output logic [1:0]                 dbg_state,
  output logic [$clog2(MAX_OUT):0]   dbg_count
);

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_I = 2'd1,
    ST_LOCK_D = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_gnt_q, last_gnt_d;
  logic [MAX_OUT-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic full;
  logic sel;      // 0 = inst, 1 = data
  logic sel_vld;  // a request is being presented downstream this cycle
  logic push;
  logic pop;
  logic head;

  assign full = (count_q == CNT_W'(MAX_OUT));

  // Requester selection. The rstn term keeps every request-side output at 0
  // while reset is asserted, even if the upstream ports keep requesting.
  always_comb begin
    sel     = 1'b0;
    sel_vld = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rstn && !full) begin
          if (inst_sram_req && data_sram_req) begin
            sel     = ~last_gnt_q;
            sel_vld = 1'b1;
          end else if (inst_sram_req) begin
            sel     = 1'b0;
            sel_vld = 1'b1;
          end else if (data_sram_req) begin
            sel     = 1'b1;
            sel_vld = 1'b1;
          end
        end
      end
      ST_LOCK_I: begin
        sel     = 1'b0;
        sel_vld = rstn && !full && inst_sram_req;
      end
      ST_LOCK_D: begin
        sel     = 1'b1;
        sel_vld = rstn && !full && data_sram_req;
      end
      default: begin
        sel     = 1'b0;
        sel_vld = 1'b0;
      end
    endcase
  end

  // Downstream request forwarding; fields are zero when nothing is selected.
  always_comb begin
    mem_req   = sel_vld;
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (sel_vld) begin
      if (sel) begin
        mem_wr    = data_sram_wr;
        mem_size  = data_sram_size;
        mem_wstrb = data_sram_wstrb;
        mem_addr  = data_sram_addr;
        mem_wdata = data_sram_wdata;
      end else begin
        mem_wr    = inst_sram_wr;
        mem_size  = inst_sram_size;
        mem_wstrb = inst_sram_wstrb;
        mem_addr  = inst_sram_addr;
        mem_wdata = inst_sram_wdata;
      end
    end
  end

  assign push = sel_vld & mem_addr_ok;
  assign pop  = mem_data_ok & (count_q != '0);
  assign head = fifo_q[rd_ptr_q];

  assign inst_sram_addr_ok = push & ~sel;
  assign data_sram_addr_ok = push &  sel;

  // A response with nothing outstanding is dropped: pop is already gated.
  assign inst_sram_data_ok = pop & ~head;
  assign data_sram_data_ok = pop &  head;
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  assign dbg_state = state_q;
  assign dbg_count = count_q;

  // Next-state / round-robin pointer.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (push) begin
          last_gnt_d = sel;
        end else if (sel_vld) begin
          state_d = sel ? ST_LOCK_D : ST_LOCK_I;
        end
      end
      ST_LOCK_I: begin
        if (push) begin
          state_d    = ST_IDLE;
          last_gnt_d = 1'b0;
        end else if (!inst_sram_req) begin
          // Requester withdrew mid-handshake: release without a push.
          state_d = ST_IDLE;
        end
      end
      ST_LOCK_D: begin
        if (push) begin
          state_d    = ST_IDLE;
          last_gnt_d = 1'b1;
        end else if (!data_sram_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // In-order ID FIFO; pointers wrap naturally because MAX_OUT is a power of 2.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 1'b0;
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule
